// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared constants and helpers for the radix-8 Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Booth multiple select; sign is carried separately as a neg flag
    localparam logic [2:0] SEL_ZERO = 3'd0;
    localparam logic [2:0] SEL_M1   = 3'd1;
    localparam logic [2:0] SEL_M2   = 3'd2;
    localparam logic [2:0] SEL_M3   = 3'd3;
    localparam logic [2:0] SEL_M4   = 3'd4;

    // Number of radix-8 digits needed to cover width+1 bits
    function automatic int n_iter(input int width);
        return (width + 3) / 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r8_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r8_recoder
//  Description : Maps {Q[2:0], q_m1} to a radix-8 Booth multiple and sign.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r8_recoder
    import mul_pkg::*;
(
    input  logic [3:0] digit_bits,
    output logic [2:0] sel,
    output logic       neg
);

    // d = -4*q2 + 2*q1 + q0 + q_m1; zero is never flagged negative
    always_comb begin
        sel = SEL_ZERO;
        neg = 1'b0;
        case (digit_bits)
            4'b0001, 4'b0010: sel = SEL_M1;
            4'b0011, 4'b0100: sel = SEL_M2;
            4'b0101, 4'b0110: sel = SEL_M3;
            4'b0111:          sel = SEL_M4;
            4'b1000:          begin sel = SEL_M4; neg = 1'b1; end
            4'b1001, 4'b1010: begin sel = SEL_M3; neg = 1'b1; end
            4'b1011, 4'b1100: begin sel = SEL_M2; neg = 1'b1; end
            4'b1101, 4'b1110: begin sel = SEL_M1; neg = 1'b1; end
            default:          begin sel = SEL_ZERO; neg = 1'b0; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_r8_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r8_seq_mul
//  Description : Sequential radix-8 Booth multiplier, one digit per clock,
//                start/busy/done handshake, signed/unsigned, abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r8_seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N_ITER = n_iter(WIDTH);
    localparam int QW     = 3 * N_ITER;
    localparam int AW     = WIDTH + 3;
    localparam int PW     = 2 * WIDTH;
    localparam int CW     = $clog2(N_ITER + 1);
    localparam logic [CW-1:0] C_LAST = CW'(N_ITER - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_a;
    logic [QW-1:0] r_q;
    logic          r_qm1;
    logic [AW-1:0] r_m;
    logic [AW-1:0] r_m3;
    logic          r_busy;
    logic          r_done;
    logic [PW-1:0] r_product;

    logic [1:0]    w_state_nxt;
    logic          w_start_ok;
    logic          w_step;
    logic          w_last;
    logic [QW-1:0] w_x_ext;
    logic [AW-1:0] w_y_ext;
    logic [2:0]    w_sel;
    logic          w_neg;
    logic [AW-1:0] w_mult;
    logic [AW-1:0] w_addend;
    logic [AW-1:0] w_sum;
    logic [AW-1:0] w_a_sh;
    logic [QW-1:0] w_q_sh;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_step     = (r_state == S_RUN) && !abort;
    assign w_last     = (r_cnt == C_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (abort)       w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand extension: the extra top bits make unsigned values look positive
    assign w_x_ext = {{(QW-WIDTH){signed_mode & x[WIDTH-1]}}, x};
    assign w_y_ext = {{(AW-WIDTH){signed_mode & y[WIDTH-1]}}, y};

    booth_r8_recoder u_recoder (
        .digit_bits ({r_q[2:0], r_qm1}),
        .sel        (w_sel),
        .neg        (w_neg)
    );

    always_comb begin
        w_mult = '0;
        case (w_sel)
            SEL_M1:  w_mult = r_m;
            SEL_M2:  w_mult = {r_m[AW-2:0], 1'b0};
            SEL_M3:  w_mult = r_m3;
            SEL_M4:  w_mult = {r_m[AW-3:0], 2'b00};
            default: w_mult = '0;
        endcase
    end

    // Subtraction as invert plus carry-in keeps a single adder
    assign w_addend = w_neg ? ~w_mult : w_mult;
    assign w_sum    = r_a + w_addend + {{(AW-1){1'b0}}, w_neg};
    assign w_a_sh   = {{3{w_sum[AW-1]}}, w_sum[AW-1:3]};
    assign w_q_sh   = {w_sum[2:0], r_q[QW-1:3]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_m       <= '0;
            r_m3      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_start_ok) begin
                r_cnt <= '0;
                r_a   <= '0;
                r_q   <= w_x_ext;
                r_qm1 <= 1'b0;
                r_m   <= w_y_ext;
                r_m3  <= w_y_ext + {w_y_ext[AW-2:0], 1'b0};
            end else if (w_step) begin
                r_cnt <= r_cnt + C_ONE;
                r_a   <= w_a_sh;
                r_q   <= w_q_sh;
                r_qm1 <= r_q[2];
                if (w_last) r_product <= {w_a_sh[PW-QW-1:0], w_q_sh};
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_r8_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_r8_seq_mul
//  Description : Scoreboard bench for booth_r8_seq_mul at WIDTH=32 and WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_r8_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        start32, sm32, abort32, busy32, done32;
    logic [31:0] x32, y32;
    logic [63:0] p32;
    logic        start8, sm8, abort8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] p8;

    logic [63:0] q32[$];
    logic [15:0] q8[$];
    logic [63:0] last32;
    int n_pass  = 0;
    int n_total = 0;

    booth_r8_seq_mul #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_b(rst_b), .start(start32), .signed_mode(sm32),
        .abort(abort32), .x(x32), .y(y32), .busy(busy32), .done(done32),
        .product(p32)
    );

    booth_r8_seq_mul #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8),
        .abort(abort8), .x(x8), .y(y8), .busy(busy8), .done(done8),
        .product(p8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] model32(input logic sm, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sm ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sm ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = sm ? {{8{a[7]}}, a} : {8'd0, a};
        eb = sm ? {{8{b[7]}}, b} : {8'd0, b};
        return ea * eb;
    endfunction

    // Scoreboard: every done pops one expected product
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) chk("done32_unexpected", 64'd1, 64'd0);
            else                 chk("prod32", p32, q32.pop_front());
        end
        if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
            else                chk("prod8", 64'(p8), 64'(q8.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Drives start for cycle 0; returns in cycle 1
    task automatic launch32(input logic sm, input logic [31:0] a, input logic [31:0] b, input bit push);
        start32 = 1'b1; sm32 = sm; x32 = a; y32 = b;
        if (push) begin
            q32.push_back(model32(sm, a, b));
            last32 = model32(sm, a, b);
        end
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic wait_done32(input int cyc_now, output int cyc);
        cyc = cyc_now;
        while (!done32 && cyc < 60) begin
            chk("busy32", 64'(busy32), 64'd1);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic op32(input logic sm, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        launch32(sm, a, b, 1'b1);
        wait_done32(1, cyc);
        chk("lat32", 64'(cyc), 64'd12);
        chk("busy_in_done32", 64'(busy32), 64'd0);
        @(negedge clk);
        chk("done_pulse32", 64'(done32), 64'd0);
        chk("hold32", p32, last32);
    endtask

    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        start8 = 1'b1; sm8 = sm; x8 = a; y8 = b;
        q8.push_back(model8(sm, a, b));
        @(negedge clk);
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("lat8", 64'(cyc), 64'd4);
        @(negedge clk);
        chk("done_pulse8", 64'(done8), 64'd0);
    endtask

    initial begin
        int cyc;
        logic seen;
        rst_b = 1'b0;
        start32 = 1'b0; sm32 = 1'b0; abort32 = 1'b0; x32 = '0; y32 = '0;
        start8  = 1'b0; sm8  = 1'b0; abort8  = 1'b0; x8  = '0; y8  = '0;
        last32 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_prod", p32, 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        op32(1'b1, 32'd72, 32'd89);
        chk("prod_72x89", p32, 64'd6408);
        op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("prod_m1xm1", p32, 64'd1);
        op32(1'b1, 32'h8000_0000, 32'h8000_0000);
        op32(1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
        chk("prod_min_max", p32, 64'hC000_0000_8000_0000);
        op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("prod_u_max", p32, 64'hFFFF_FFFE_0000_0001);
        for (int i = 0; i < 8; i++)
            op32(1'(i & 1), $urandom, $urandom);

        // start re-pulsed at cycle 5 must be ignored
        launch32(1'b1, 32'd1234, 32'hFFFF_E9D2, 1'b1);
        repeat (4) @(negedge clk);
        start32 = 1'b1; x32 = 32'd777; y32 = 32'd999;
        @(negedge clk);
        start32 = 1'b0;
        wait_done32(6, cyc);
        chk("lat_repulse", 64'(cyc), 64'd12);
        @(negedge clk);

        // start held into DONE launches a back-to-back operation
        launch32(1'b0, 32'd100_000, 32'd300_000, 1'b1);
        repeat (10) @(negedge clk);
        start32 = 1'b1; sm32 = 1'b1; x32 = 32'hFFFF_FF00; y32 = 32'd12345;
        q32.push_back(model32(1'b1, 32'hFFFF_FF00, 32'd12345));
        last32 = model32(1'b1, 32'hFFFF_FF00, 32'd12345);
        @(negedge clk);
        chk("b2b_done1", 64'(done32), 64'd1);
        @(negedge clk);
        start32 = 1'b0;
        wait_done32(1, cyc);
        chk("b2b_lat", 64'(cyc), 64'd12);
        @(negedge clk);

        // start and abort together in IDLE: start wins
        start32 = 1'b1; abort32 = 1'b1; sm32 = 1'b0; x32 = 32'd5; y32 = 32'd7;
        q32.push_back(64'd35);
        last32 = 64'd35;
        @(negedge clk);
        start32 = 1'b0; abort32 = 1'b0;
        wait_done32(1, cyc);
        chk("lat_start_abort", 64'(cyc), 64'd12);
        @(negedge clk);

        // abort in cycle 4 of RUN
        launch32(1'b1, 32'd11, 32'd13, 1'b0);
        repeat (3) @(negedge clk);
        abort32 = 1'b1;
        @(negedge clk);
        abort32 = 1'b0;
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_done", 64'(done32), 64'd0);
        chk("abort_prod", p32, last32);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | done32;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        // asynchronous reset at cycle 6
        launch32(1'b1, 32'd21, 32'd22, 1'b0);
        repeat (5) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("arst_busy", 64'(busy32), 64'd0);
        chk("arst_done", 64'(done32), 64'd0);
        chk("arst_prod", p32, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | done32 | busy32;
        end
        chk("arst_quiet", 64'(seen), 64'd0);

        // WIDTH=8 instance
        op8(1'b1, 8'h80, 8'h7F);
        chk("prod8_min_max", 64'(p8), 64'h0000_C080);
        op8(1'b0, 8'hFF, 8'hFF);
        chk("prod8_u_max", 64'(p8), 64'h0000_FE01);
        op8(1'b1, 8'h80, 8'h80);
        for (int i = 0; i < 12; i++)
            op8(1'(i & 1), 8'($urandom), 8'($urandom));

        repeat (3) @(negedge clk);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
